// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller. Produces the next PC and PC-hold for the PC
// register, drives a req/ready handshake to a multi-cycle instruction memory,
// and arbitrates redirect sources (exception, eret, jump, branch) against the
// sequential pc+4 path. Redirects that arrive while memory is busy are held
// and applied (or discarded) when the outstanding word returns.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   pc, pcadd4   current PC and PC+4 from the fetch stage
//   stall_d      hazard-unit stall (masks jump/branch)
//   br_taken/br_target, j_en/j_target   D-stage redirects
//   exc_req      exception entry (goes to EXC_VECTOR)
//   eret/epc     exception return
//   im_ready     instruction memory data valid this cycle
//   npc          next PC for the PC register
//   stall_pc     hold the PC register
//   im_req       instruction memory read request for address pc
//   fetch_valid  returned word is a valid IF/ID entry
//   flush_fd     clear the IF/ID register
//   im_timeout   one-cycle pulse when memory fails to answer in time
//   state        FSM state (0 IDLE, 1 FETCH, 2 WAIT)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned WAIT_MAX   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] pcadd4,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_en,
  input  logic [31:0] j_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        im_ready,
  output logic [31:0] npc,
  output logic        stall_pc,
  output logic        im_req,
  output logic        fetch_valid,
  output logic        flush_fd,
  output logic        im_timeout,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [1:0]  pend_prio_q, pend_prio_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        redir_valid;
  logic [31:0] redir_target;
  logic [1:0]  redir_prio;
  logic        redir_flush;
  logic        new_wins;

  // pc is only used by the PC register around us; the address presented to
  // memory is pc itself, so nothing here needs to look at it.
  logic        unused_pc;
  assign unused_pc = ^pc;

  assign state = state_q;

  // Redirect arbitration for this cycle. Priority 3 = exception down to
  // 0 = branch. Jumps and branches are masked while the hazard unit stalls
  // because D-stage has not resolved them yet.
  always_comb begin
    redir_valid  = 1'b1;
    redir_target = EXC_VECTOR;
    redir_prio   = 2'd3;
    if (exc_req) begin
      redir_target = EXC_VECTOR;
      redir_prio   = 2'd3;
    end else if (eret) begin
      redir_target = epc;
      redir_prio   = 2'd2;
    end else if (!stall_d && j_en) begin
      redir_target = j_target;
      redir_prio   = 2'd1;
    end else if (!stall_d && br_taken) begin
      redir_target = br_target;
      redir_prio   = 2'd0;
    end else begin
      redir_valid  = 1'b0;
      redir_target = pcadd4;
      redir_prio   = 2'd0;
    end
  end

  // Exception entry/return discard the word in IF; jumps and branches keep
  // it because it is the delay slot.
  assign redir_flush = exc_req | eret;

  // A new redirect replaces the held one on equal or higher priority, so the
  // most recent of equal-rank redirects is the one that sticks.
  assign new_wins = redir_valid && (!pend_valid_q || (redir_prio >= pend_prio_q));

  // State, pending redirect and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      pend_prio_q   <= 2'd0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_prio_q   <= pend_prio_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Next-state and output logic. While stalled the npc value is don't-care,
  // so it defaults to the sequential path.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_prio_d   = pend_prio_q;
    wait_cnt_d    = wait_cnt_q;
    npc           = pcadd4;
    stall_pc      = 1'b0;
    im_req        = 1'b0;
    fetch_valid   = 1'b0;
    flush_fd      = 1'b0;
    im_timeout    = 1'b0;

    case (state_q)
      S_IDLE: begin
        npc      = RESET_PC;
        flush_fd = 1'b1;
        state_d  = S_FETCH;
      end

      S_FETCH: begin
        im_req = 1'b1;
        if (im_ready) begin
          fetch_valid = 1'b1;
          npc         = redir_target;
          stall_pc    = stall_d & ~redir_flush;
          flush_fd    = redir_flush;
        end else begin
          stall_pc   = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = 8'd1;
          if (redir_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target;
            pend_prio_d   = redir_prio;
          end
        end
      end

      S_WAIT: begin
        im_req   = 1'b1;
        stall_pc = 1'b1;
        if (im_ready) begin
          state_d      = S_FETCH;
          wait_cnt_d   = 8'd0;
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            // The returned word belongs to the abandoned path: drop it and
            // steer to whichever held or fresh redirect ranks higher.
            flush_fd = 1'b1;
            stall_pc = 1'b0;
            npc      = new_wins ? redir_target : pend_target_q;
          end else begin
            fetch_valid = 1'b1;
            npc         = redir_target;
            stall_pc    = stall_d & ~redir_flush;
            flush_fd    = redir_flush;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          im_timeout   = 1'b1;
          npc          = EXC_VECTOR;
          stall_pc     = 1'b0;
          flush_fd     = 1'b1;
          pend_valid_d = 1'b0;
          wait_cnt_d   = 8'd0;
          state_d      = S_FETCH;
        end else begin
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          if (new_wins) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target;
            pend_prio_d   = redir_prio;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A small PC register model closes the
// npc/stall_pc loop so the sequencer sees a realistic pc/pcadd4 stream;
// every expected value below is a hand-computed constant.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pcadd4;
  logic        stall_d;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_en;
  logic [31:0] j_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        im_ready;
  logic [31:0] npc;
  logic        stall_pc;
  logic        im_req;
  logic        fetch_valid;
  logic        flush_fd;
  logic        im_timeout;
  logic [1:0]  state;

  int tests_run;
  int tests_failed;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_3000),
    .EXC_VECTOR(32'h0000_4180),
    .WAIT_MAX  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pcadd4     (pcadd4),
    .stall_d    (stall_d),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .j_en       (j_en),
    .j_target   (j_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .im_ready   (im_ready),
    .npc        (npc),
    .stall_pc   (stall_pc),
    .im_req     (im_req),
    .fetch_valid(fetch_valid),
    .flush_fd   (flush_fd),
    .im_timeout (im_timeout),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register the sequencer normally drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 32'h0000_3000;
    end else if (!stall_pc) begin
      pc <= npc;
    end
  end
  assign pcadd4 = pc + 32'd4;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and let the
  // combinational outputs settle before any check.
  task automatic applyStimulus(input logic rdy, input logic stl,
                               input logic br, input logic [31:0] brt,
                               input logic jn, input logic [31:0] jt,
                               input logic exc, input logic er,
                               input logic [31:0] ep);
    @(negedge clk);
    im_ready  = rdy;
    stall_d   = stl;
    br_taken  = br;
    br_target = brt;
    j_en      = jn;
    j_target  = jt;
    exc_req   = exc;
    eret      = er;
    epc       = ep;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    im_ready  = 1'b1;
    stall_d   = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    j_en      = 1'b0;
    j_target  = 32'h0;
    exc_req   = 1'b0;
    eret      = 1'b0;
    epc       = 32'h0;

    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_im_req", 32'(im_req), 32'd0);
    checkOutput("rst_flush", 32'(flush_fd), 32'd1);
    checkOutput("rst_npc", npc, 32'h3000);
    checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);

    // Cycle 0 after release: still IDLE, pointing at the reset vector.
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("idle_state", 32'(state), 32'd0);
    checkOutput("idle_npc", npc, 32'h3000);
    checkOutput("idle_flush", 32'(flush_fd), 32'd1);

    // Sequential fetch 3000, 3004.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq0_state", 32'(state), 32'd1);
    checkOutput("seq0_pc", pc, 32'h3000);
    checkOutput("seq0_valid", 32'(fetch_valid), 32'd1);
    checkOutput("seq0_npc", npc, 32'h3004);

    // Memory busy at 3004 for three cycles.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq1_pc", pc, 32'h3004);
    checkOutput("busy_stall", 32'(stall_pc), 32'd1);
    checkOutput("busy_valid", 32'(fetch_valid), 32'd0);
    checkOutput("busy_req", 32'(im_req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("wait_state", 32'(state), 32'd2);
      checkOutput("wait_stall", 32'(stall_pc), 32'd1);
      checkOutput("wait_req", 32'(im_req), 32'd1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_valid", 32'(fetch_valid), 32'd1);
    checkOutput("ready_npc", npc, 32'h3008);
    checkOutput("ready_stall", 32'(stall_pc), 32'd0);
    checkOutput("ready_flush", 32'(flush_fd), 32'd0);

    // Branch arrives while waiting; returned word is discarded.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq2_pc", pc, 32'h3008);
    applyStimulus(0, 0, 1, 32'h3100, 0, 0, 0, 0, 0);
    checkOutput("wbr_stall", 32'(stall_pc), 32'd1);
    checkOutput("wbr_flush", 32'(flush_fd), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_flush", 32'(flush_fd), 32'd1);
    checkOutput("pend_valid", 32'(fetch_valid), 32'd0);
    checkOutput("pend_npc", npc, 32'h3100);
    checkOutput("pend_stall", 32'(stall_pc), 32'd0);

    // Exception beats a jump and overrides stall.
    applyStimulus(1, 1, 0, 0, 1, 32'h3200, 1, 0, 0);
    checkOutput("exc_pc", pc, 32'h3100);
    checkOutput("exc_npc", npc, 32'h4180);
    checkOutput("exc_stall", 32'(stall_pc), 32'd0);
    checkOutput("exc_flush", 32'(flush_fd), 32'd1);

    // Branch masked by stall, then taken once the stall clears.
    applyStimulus(1, 1, 1, 32'h3400, 0, 0, 0, 0, 0);
    checkOutput("stbr_stall", 32'(stall_pc), 32'd1);
    checkOutput("stbr_npc", npc, 32'h4184);
    checkOutput("stbr_flush", 32'(flush_fd), 32'd0);
    applyStimulus(1, 0, 1, 32'h3400, 0, 0, 0, 0, 0);
    checkOutput("br_pc", pc, 32'h4180);
    checkOutput("br_npc", npc, 32'h3400);
    checkOutput("br_flush", 32'(flush_fd), 32'd0);
    checkOutput("br_stall", 32'(stall_pc), 32'd0);

    // Timeout in the eighth wait cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_pc", pc, 32'h3400);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 8) begin
        checkOutput("to_quiet", 32'(im_timeout), 32'd0);
        checkOutput("to_state", 32'(state), 32'd2);
      end else begin
        checkOutput("to_pulse", 32'(im_timeout), 32'd1);
        checkOutput("to_npc", npc, 32'h4180);
        checkOutput("to_stall", 32'(stall_pc), 32'd0);
        checkOutput("to_flush", 32'(flush_fd), 32'd1);
        checkOutput("to_valid", 32'(fetch_valid), 32'd0);
      end
    end

    // Ready in the eighth wait cycle beats the timeout.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_to_state", 32'(state), 32'd1);
    checkOutput("after_to_pulse", 32'(im_timeout), 32'd0);
    checkOutput("after_to_pc", pc, 32'h4180);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(logic'(i == 8), 0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("late_rdy_pulse", 32'(im_timeout), 32'd0);
    checkOutput("late_rdy_valid", 32'(fetch_valid), 32'd1);
    checkOutput("late_rdy_npc", npc, 32'h4184);

    // Held eret outranks a later jump and a same-cycle branch.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pr_pc", pc, 32'h4184);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h5000);
    applyStimulus(0, 0, 0, 0, 1, 32'h6000, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h7000, 0, 0, 0, 0, 0);
    checkOutput("pr_eret_npc", npc, 32'h5000);
    checkOutput("pr_eret_flush", 32'(flush_fd), 32'd1);

    // Same-cycle jump outranks a held branch.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pr2_pc", pc, 32'h5000);
    applyStimulus(0, 0, 1, 32'h7100, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h7200, 0, 0, 0);
    checkOutput("pr_jmp_npc", npc, 32'h7200);
    checkOutput("pr_jmp_valid", 32'(fetch_valid), 32'd0);

    // Reset mid-wait drops the request and the held jump.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_pc", pc, 32'h7200);
    applyStimulus(0, 0, 0, 0, 1, 32'h7300, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_req_before", 32'(im_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mr_req", 32'(im_req), 32'd0);
    checkOutput("mr_state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mr_idle", 32'(state), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_fetch_state", 32'(state), 32'd1);
    checkOutput("mr_fetch_npc", npc, 32'h3004);
    checkOutput("mr_fetch_flush", 32'(flush_fd), 32'd0);
    checkOutput("mr_fetch_valid", 32'(fetch_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
